pulse_extender_multi: RTL and testbench

// Parametrised successor to the fixed 3-cycle pulse extender. Each of CHANNELS

---
 rtl/pulse_extender_multi_if.sv | 26 ++
 rtl/pulse_extender_multi.sv | 97 +++++++++
 tb/tb_pulse_extender_multi.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pulse_extender_multi_if.sv
// Bus bundle for pulse_extender_multi: trigger controls in, extended pulses out.
// Optional feature macro: PULSE_EXT_DROP_CNT_EN adds the per-channel drop counters.
interface pulse_extender_multi_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned DROP_W   = 8
);
  logic                en;
  logic [LEN_W-1:0]    len;
  logic [CHANNELS-1:0] d;
  logic [CHANNELS-1:0] q;
`ifdef PULSE_EXT_DROP_CNT_EN
  logic [CHANNELS*DROP_W-1:0] drop_cnt;

  modport master (output en, len, d, input q, drop_cnt);
  modport slave  (input en, len, d, output q, drop_cnt);
`else
  modport master (output en, len, d, input q);
  modport slave  (input en, len, d, output q);
`endif

  // Reject degenerate configurations at elaboration time
  if (CHANNELS < 1 || LEN_W < 1 || DROP_W < 1) begin : g_bad_param
    $error("pulse_extender_multi_if: CHANNELS, LEN_W and DROP_W must be >= 1");
  end
endinterface

// File: rtl/pulse_extender_multi.sv
// Multi-channel pulse extender: a rising edge on d[i] drives q[i] high for a
// run-time programmable number of cycles, with optional retriggering.
// Optional feature macro: PULSE_EXT_DROP_CNT_EN (saturating dropped-trigger counters).
module pulse_extender_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned RETRIGGER = 1,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pulse_extender_multi_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} ch_state_t;

  logic [LEN_W-1:0]    eff_len;
  logic [CHANNELS-1:0] d_prev;
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] q_next;
  logic [LEN_W-1:0]    cnt      [CHANNELS];
  logic [LEN_W-1:0]    cnt_next [CHANNELS];
  ch_state_t           state    [CHANNELS];

  // A programmed length of zero still yields a one-cycle pulse
  always_comb eff_len = (bus.len == '0) ? LEN_W'(1) : bus.len;

  // Per-channel edge detect and down-counter next state; the counter itself is the state
  always_comb begin
    trig   = '0;
    q_next = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state[i]    = (cnt[i] != '0) ? ACTIVE : IDLE;
      cnt_next[i] = cnt[i];
      trig[i]     = bus.en & bus.d[i] & ~d_prev[i];
      case (state[i])
        IDLE: begin
          if (trig[i]) cnt_next[i] = eff_len;
        end
        ACTIVE: begin
          if (trig[i] && (RETRIGGER != 0)) cnt_next[i] = eff_len;
          else                             cnt_next[i] = cnt[i] - LEN_W'(1);
        end
        default: cnt_next[i] = cnt[i];
      endcase
      q_next[i] = (cnt_next[i] != '0);
    end
  end

  // Counter, output and edge-history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_prev <= '0;
      bus.q  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      d_prev <= bus.d;
      bus.q  <= q_next;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= cnt_next[i];
    end
  end

`ifdef PULSE_EXT_DROP_CNT_EN
  logic [CHANNELS-1:0] drop;
  logic [DROP_W-1:0]   drops [CHANNELS];

  // A drop is an accepted edge that arrives while a non-retriggerable pulse is running
  always_comb begin
    drop = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      drop[i] = trig[i] && (state[i] == ACTIVE) && (RETRIGGER == 0);
  end

  // Saturating drop counters, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) drops[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++)
        if (drop[i] && (drops[i] != '1)) drops[i] <= drops[i] + DROP_W'(1);
    end
  end

  // Flatten counters onto the bus, channel i at [i*DROP_W +: DROP_W]
  always_comb begin
    bus.drop_cnt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      bus.drop_cnt[i*DROP_W +: DROP_W] = drops[i];
  end
`endif

  // Reject degenerate configurations at elaboration time
  if (CHANNELS < 1 || LEN_W < 1 || DROP_W < 1) begin : g_bad_param
    $error("pulse_extender_multi: CHANNELS, LEN_W and DROP_W must be >= 1");
  end

endmodule

// File: tb/tb_pulse_extender_multi.sv
// Bench for pulse_extender_multi: one retriggering and one non-retriggering
// instance share stimulus and are compared every cycle against an end-time model.
module tb_pulse_extender_multi;
  localparam int CH  = 4;
  localparam int LW  = 8;
  localparam int DW1 = 8;
  localparam int DW0 = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [LW-1:0] len;
  logic [CH-1:0] d;

  int tests = 0;
  int fails = 0;
  int t     = 0;

  // Model: each pulse is an end time; q after edge t is high while t < until
  int until_rt [CH];
  int until_nr [CH];
  int drops_rt [CH];
  int drops_nr [CH];
  bit dprev    [CH];

  pulse_extender_multi_if #(.CHANNELS(CH), .LEN_W(LW), .DROP_W(DW1)) if_rt ();
  pulse_extender_multi_if #(.CHANNELS(CH), .LEN_W(LW), .DROP_W(DW0)) if_nr ();

  assign if_rt.en = en;  assign if_rt.len = len;  assign if_rt.d = d;
  assign if_nr.en = en;  assign if_nr.len = len;  assign if_nr.d = d;

  pulse_extender_multi #(.CHANNELS(CH), .LEN_W(LW), .RETRIGGER(1), .DROP_W(DW1)) dut_rt (
    .clk(clk), .rst(rst), .bus(if_rt));
  pulse_extender_multi #(.CHANNELS(CH), .LEN_W(LW), .RETRIGGER(0), .DROP_W(DW0)) dut_nr (
    .clk(clk), .rst(rst), .bus(if_nr));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      until_rt[i] = -1000; until_nr[i] = -1000;
      drops_rt[i] = 0;     drops_nr[i] = 0;
      dprev[i]    = 1'b0;
    end
  endtask

  task automatic model_edge();
    int  el;
    bit  trg;
    el = (len == 0) ? 1 : int'(len);
    for (int i = 0; i < CH; i++) begin
      trg = en && d[i] && !dprev[i];
      if (trg) until_rt[i] = t + el;
      if (trg) begin
        if (t - 1 < until_nr[i]) begin
          if (drops_nr[i] < (1 << DW0) - 1) drops_nr[i]++;
        end else begin
          until_nr[i] = t + el;
        end
      end
      dprev[i] = d[i];
    end
  endtask

  task automatic check(input string tag);
    logic [CH-1:0]     exp_rt, exp_nr;
    logic [CH*DW1-1:0] exp_d1;
    logic [CH*DW0-1:0] exp_d0;
    int                v;
    for (int i = 0; i < CH; i++) begin
      exp_rt[i] = (t < until_rt[i]);
      exp_nr[i] = (t < until_nr[i]);
      v = drops_rt[i]; exp_d1[i*DW1 +: DW1] = v[DW1-1:0];
      v = drops_nr[i]; exp_d0[i*DW0 +: DW0] = v[DW0-1:0];
    end
    tests++;
    assert (if_rt.q === exp_rt) else begin
      fails++;
      $error("FAIL %s q_retrig t=%0d observed=%b expected=%b", tag, t, if_rt.q, exp_rt);
    end
    tests++;
    assert (if_nr.q === exp_nr) else begin
      fails++;
      $error("FAIL %s q_noretrig t=%0d observed=%b expected=%b", tag, t, if_nr.q, exp_nr);
    end
`ifdef PULSE_EXT_DROP_CNT_EN
    tests++;
    assert (if_rt.drop_cnt === exp_d1) else begin
      fails++;
      $error("FAIL %s drop_retrig t=%0d observed=%h expected=%h", tag, t, if_rt.drop_cnt, exp_d1);
    end
    tests++;
    assert (if_nr.drop_cnt === exp_d0) else begin
      fails++;
      $error("FAIL %s drop_noretrig t=%0d observed=%h expected=%h", tag, t, if_nr.drop_cnt, exp_d0);
    end
`else
    v = exp_d1[0] ^ exp_d0[0];
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    t++;
    model_edge();
    #1;
    check(tag);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; len = 8'd5; d = '1;
    model_reset();
    #1 check("reset_async");
    repeat (3) @(posedge clk);
    #1 check("reset_hold");

    // Release with d high: edge counted on the first clock
    @(negedge clk) rst = 1'b1;
    repeat (7) tick("release_d_high");

    // Basic lengths: 3, 0 (one cycle), 255
    d = '0; len = 8'd3; tick("basic_idle");
    d = 4'b0001; tick("len3_edge");
    d = '0; repeat (5) tick("len3_run");
    len = 8'd0; d = 4'b0001; tick("len0_edge");
    d = '0; repeat (3) tick("len0_run");
    len = 8'd255; d = 4'b0001; tick("len255_edge");
    d = '0; repeat (258) tick("len255_run");

    // Edges two cycles apart on d[1]: retrigger vs drop, last one at cnt==1
    len = 8'd4;
    for (int k = 0; k < 3; k++) begin
      d = 4'b0010; tick("retrig_edge");
      d = 4'b0000; tick("retrig_gap");
    end
    repeat (8) tick("retrig_tail");

    // Edge right after q falls: 1-cycle pulse then immediate re-edge
    len = 8'd1; d = 4'b0100; tick("gap_edge1");
    d = '0; tick("gap_low");
    d = 4'b0100; tick("gap_edge2");
    d = '0; repeat (3) tick("gap_tail");

    // Enable masking, pulse completion with en low, len change mid-pulse
    len = 8'd4; en = 1'b0; d = 4'b0001; tick("en_low_edge");
    d = '0; repeat (3) tick("en_low_idle");
    en = 1'b1; d = 4'b0001; tick("en_mid_edge");
    en = 1'b0; d = '0; repeat (6) tick("en_mid_run");
    en = 1'b0; d = 4'b1000; repeat (2) tick("en_level_hold");
    en = 1'b1; repeat (3) tick("en_level_rise");
    d = '0; tick("en_level_drop");
    len = 8'd3; d = 4'b0001; tick("len_chg_edge");
    len = 8'd9; d = '0; repeat (12) tick("len_chg_run");

    // Many drops during one long pulse on all channels at once
    len = 8'd20;
    for (int k = 0; k < 6; k++) begin
      d = '1; tick("sat_edge");
      d = '0; tick("sat_gap");
    end
    repeat (14) tick("sat_tail");

    // Asynchronous reset mid-pulse, between clock edges
    len = 8'd6; d = '1; tick("arst_edge");
    d = '0; tick("arst_run");
    rst = 1'b0; model_reset();
    #1 check("arst_clear");
    @(negedge clk) rst = 1'b1;
    repeat (3) tick("arst_after");

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0) d = CH'($urandom);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) len = LW'($urandom_range(0, 12));
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
